// File: rtl/sync_debounce_edge_if.sv
// Signal bundle between the debounce stage and its consumer.
// The debounce block uses the slave view; the driver of din/clr uses the master view.
interface sync_debounce_edge_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 din;
    logic                 clr;
    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] rise_cnt;
    logic [CNT_WIDTH-1:0] glitch_cnt;

    modport master (
        output din,
        output clr,
        input  level,
        input  rise,
        input  fall,
        input  rise_cnt,
        input  glitch_cnt
    );

    modport slave (
        input  din,
        input  clr,
        output level,
        output rise,
        output fall,
        output rise_cnt,
        output glitch_cnt
    );
endinterface

// File: rtl/sync_debounce_edge.sv
// Debounce of an already-synchronized level with rise/fall pulses and
// saturating counters of accepted rising edges and rejected glitches.
module sync_debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sync_debounce_edge_if.slave     bus
);

    typedef enum logic [1:0] {
        S_LOW,
        S_PEND_HIGH,
        S_HIGH,
        S_PEND_LOW
    } state_e;

    localparam logic [15:0] LAST_CNT = 16'(STABLE_CYCLES - 1);

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [CNT_WIDTH-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_WIDTH-1:0] glitch_cnt_q, glitch_cnt_d;
    logic                 rise_evt;
    logic                 glitch_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOW;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            rise_cnt_q   <= '0;
            glitch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            rise_cnt_q   <= rise_cnt_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        rise_evt   = 1'b0;
        glitch_evt = 1'b0;

        unique case (state_q)
            S_LOW: begin
                if (bus.din) begin
                    cnt_d   = 16'd1;
                    state_d = S_PEND_HIGH;
                end
            end
            S_PEND_HIGH: begin
                if (!bus.din) begin
                    cnt_d      = '0;
                    state_d    = S_LOW;
                    glitch_evt = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    state_d  = S_HIGH;
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    rise_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HIGH: begin
                if (!bus.din) begin
                    cnt_d   = 16'd1;
                    state_d = S_PEND_LOW;
                end
            end
            S_PEND_LOW: begin
                if (bus.din) begin
                    cnt_d      = '0;
                    state_d    = S_HIGH;
                    glitch_evt = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_LOW;
                level_d = 1'b0;
            end
        endcase
    end

    // clr wins over a coinciding increment; the event itself is simply not counted
    always_comb begin
        rise_cnt_d   = rise_cnt_q;
        glitch_cnt_d = glitch_cnt_q;
        if (bus.clr) begin
            rise_cnt_d   = '0;
            glitch_cnt_d = '0;
        end else begin
            if (rise_evt && !(&rise_cnt_q)) begin
                rise_cnt_d = rise_cnt_q + CNT_WIDTH'(1);
            end
            if (glitch_evt && !(&glitch_cnt_q)) begin
                glitch_cnt_d = glitch_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.level      = level_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.rise_cnt   = rise_cnt_q;
    assign bus.glitch_cnt = glitch_cnt_q;

endmodule

// File: doc/sync_debounce_edge.md
# sync_debounce_edge

Debounce and edge-event stage placed directly downstream of the two-flop input synchronizer. Takes the already-synchronized single-bit level and requires it to hold steady for `STABLE_CYCLES` consecutive clocks before accepting a change. Emits the qualified level, one-cycle rise/fall pulses, and saturating counters of accepted rising edges and rejected glitches for downstream logic and debug.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical samples required to accept a level change; legal range 2 to 2^16-1.
- `CNT_WIDTH`, default 8: width of `rise_cnt` and `glitch_cnt`.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  1  synchronized level from the synchronizer stage; treated as metastability-free.
- `clr`  input  1  synchronous clear of both counters.
- `level`  output  1  debounced level.
- `rise`  output  1  one-cycle pulse on an accepted 0->1 change.
- `fall`  output  1  one-cycle pulse on an accepted 1->0 change.
- `rise_cnt`  output  CNT_WIDTH  accepted rising edges, saturating.
- `glitch_cnt`  output  CNT_WIDTH  rejected pending changes, saturating.

## Operation
- FSM states: LOW, PEND_HIGH, HIGH, PEND_LOW. Internal stability counter `cnt` is 16 bits wide.
- LOW:
  - `din`=1: load `cnt`=1 and go to PEND_HIGH.
  - Otherwise stay in LOW.
- PEND_HIGH:
  - `din`=0: return to LOW, clear `cnt`, increment `glitch_cnt`.
  - `din`=1 and `cnt`==STABLE_CYCLES-1: go to HIGH, set `level`=1, pulse `rise`, increment `rise_cnt`.
  - `din`=1 otherwise: increment `cnt`.
- HIGH and PEND_LOW mirror LOW and PEND_HIGH with polarity inverted.
  - Acceptance sets `level`=0 and pulses `fall`.
  - A glitch back to 1 returns to HIGH and increments `glitch_cnt`.
  - Falling edges are not counted.
- `level` only changes on an accepted transition. It is 1 in HIGH and PEND_LOW, and 0 in LOW and PEND_HIGH.
- Counters saturate at all-ones and never wrap.
- `clr` has priority over any increment in the same cycle. The coinciding event is dropped from the count and the counter reads 0. The `rise` pulse still fires.
- All outputs are registered; there is no combinational path from `din` to any output.

## Timing
- Reset values: state LOW, `cnt`=0, `level`=0, `rise`=0, `fall`=0, `rise_cnt`=0, `glitch_cnt`=0.
- Reset asserted mid-pending aborts the pending change with no pulse and no glitch count.
- If `din`=1 continuously from reset release, `level` rises after STABLE_CYCLES clocks and `rise` pulses once.
- Latency: if `din` is sampled 1 at edges k through k+STABLE_CYCLES-1 while in LOW:
  - `level`=1 and `rise`=1 become visible immediately after edge k+STABLE_CYCLES-1.
  - `rise` returns to 0 after the next edge.
- Falling direction has identical latency.
- A pulse of STABLE_CYCLES-1 samples is rejected: exactly one glitch count, no level change.
- `rise` and `fall` are never high in the same cycle.
- Minimum spacing between two pulses is STABLE_CYCLES cycles.
- `clr` takes effect at the next edge; counters read 0 in the following cycle.

## Test plan
1. **Reset:** `STABLE_CYCLES`=4, `CNT_WIDTH`=4; hold `rst` 3 cycles with `din`=1 -> all outputs 0 during reset. After release, `level`=1 and a single `rise` pulse appear after the 4th clock, and `rise_cnt`=1.
2. **Clean edges:** drive `din` 0->1, hold 10 cycles, then 1->0, hold 10 cycles -> `rise` exactly 4 edges after the change, `fall` 4 edges after the drop, each 1 cycle wide. Final `rise_cnt`=1, `glitch_cnt`=0.
3. **Glitch rejection:** high pulses of 1, 2 and 3 cycles, separated by 6 low cycles -> `level` stays 0, no `rise`, `glitch_cnt`=3. Repeat inverted from a HIGH start -> no `fall`, `glitch_cnt` increments by 3.
4. **Saturation and clear:** 20 clean rising edges -> `rise_cnt` stops at 15. Assert `clr` on the same cycle as the 21st `rise` -> `rise` pulses and `rise_cnt`=0 next cycle. The 22nd edge gives `rise_cnt`=1.
5. **Reset mid-pending:** `din`=1 for 2 cycles from LOW, then assert `rst` for 1 cycle -> no `rise`, `glitch_cnt`=0. With `din` still 1, requalification takes 4 full cycles after release.
6. **Randomized bounce:** random `din` with bursts of 1-6 cycles, checked against a reference model -> exact match of `level`, `rise`, `fall`, `rise_cnt` and `glitch_cnt` every cycle.
